// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: groups the sequencer's memory, PC-unit and datapath signals.
//   master : sequencer side (drives mem_rd, load_ir, incp, tsel, execb, cond,
//            dp_start, halted, err, retired; samples mem_rdy, instr, dp_done)
//   slave  : environment side (memory, IR, PC unit, datapath)
interface pc_sequencer_if;
   logic        mem_rdy;
   logic [15:0] instr;
   logic        dp_done;
   logic        mem_rd;
   logic        load_ir;
   logic        incp;
   logic        tsel;
   logic        execb;
   logic [2:0]  cond;
   logic        dp_start;
   logic        halted;
   logic        err;
   logic [15:0] retired;

   modport master (
      input  mem_rdy, instr, dp_done,
      output mem_rd, load_ir, incp, tsel, execb, cond, dp_start, halted, err, retired
   );

   modport slave (
      output mem_rdy, instr, dp_done,
      input  mem_rd, load_ir, incp, tsel, execb, cond, dp_start, halted, err, retired
   );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/execute controller for the PC unit and IR.
//   clk, reset (async, active-low)
//   bus.master : mem_rdy/instr/dp_done in; mem_rd, load_ir, incp, tsel, execb,
//                cond, dp_start, halted, err, retired out
// Optional macro PC_SEQ_RETIRE_CNT_EN adds a 16-bit retired-instruction counter;
// without it retired is tied to zero.
module pc_sequencer #(
   parameter int unsigned WAIT_MAX = 15,
   parameter int unsigned CNT_W    = 8
) (
   input  logic           clk,
   input  logic           reset,
   pc_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      S_RST, S_FETCH, S_LOADIR, S_DECODE, S_EXEC, S_BRANCH, S_HALT, S_ERROR
   } state_t;

   // Counter value seen in the last permitted wait cycle.
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             br_tsel_q, br_tsel_d;
   logic [2:0]       br_cond_q, br_cond_d;

   logic       mem_rd_d, load_ir_d, incp_d, tsel_d, execb_d, dp_start_d, halted_d, err_d;
   logic [2:0] cond_d;
   logic       mem_rd_q, load_ir_q, incp_q, tsel_q, execb_q, dp_start_q, halted_q, err_q;
   logic [2:0] cond_q;

   logic [2:0] opcode;
   logic [1:0] op;
   logic       unused_instr_bits;

   assign opcode            = bus.instr[15:13];
   assign op                = bus.instr[12:11];
   assign unused_instr_bits = ^bus.instr[7:0];

   // Next state, wait counter, branch latch and next output values.
   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      br_tsel_d = br_tsel_q;
      br_cond_d = br_cond_q;

      case (state_q)
         S_RST:    state_d = S_FETCH;
         S_FETCH: begin
            if (bus.mem_rdy)           state_d = S_LOADIR;
            else if (cnt_q == WAIT_LAST) state_d = S_ERROR;
            else                       cnt_d   = cnt_q + CNT_ONE;
         end
         S_LOADIR: state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               3'd1: begin
                  state_d   = S_BRANCH;
                  br_tsel_d = 1'b1;
                  br_cond_d = bus.instr[10:8];
               end
               3'd2: begin
                  if (op == 2'b00) begin
                     state_d   = S_BRANCH;
                     br_tsel_d = 1'b0;
                     br_cond_d = 3'b000;
                  end else begin
                     state_d = S_ERROR;
                  end
               end
               3'd3, 3'd4, 3'd5, 3'd6: state_d = S_EXEC;
               3'd7:                   state_d = S_HALT;
               default:                state_d = S_ERROR;
            endcase
         end
         S_BRANCH: state_d = S_FETCH;
         S_EXEC: begin
            if (bus.dp_done)           state_d = S_FETCH;
            else if (cnt_q == WAIT_LAST) state_d = S_ERROR;
            else                       cnt_d   = cnt_q + CNT_ONE;
         end
         S_HALT:   state_d = S_HALT;
         S_ERROR:  state_d = S_ERROR;
         default:  state_d = S_ERROR;
      endcase

      // Outputs are registered from the state being entered.
      mem_rd_d   = (state_d == S_FETCH);
      load_ir_d  = (state_d == S_LOADIR);
      incp_d     = (state_d == S_LOADIR);
      execb_d    = (state_d == S_BRANCH);
      tsel_d     = execb_d & br_tsel_d;
      cond_d     = execb_d ? br_cond_d : 3'b000;
      dp_start_d = (state_d == S_EXEC) && (state_q != S_EXEC);
      halted_d   = (state_d == S_HALT) || (state_d == S_ERROR);
      err_d      = (state_d == S_ERROR);
   end

   // State, counter, branch latch and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_RST;
         cnt_q      <= '0;
         br_tsel_q  <= 1'b0;
         br_cond_q  <= 3'b000;
         mem_rd_q   <= 1'b0;
         load_ir_q  <= 1'b0;
         incp_q     <= 1'b0;
         tsel_q     <= 1'b0;
         execb_q    <= 1'b0;
         cond_q     <= 3'b000;
         dp_start_q <= 1'b0;
         halted_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         br_tsel_q  <= br_tsel_d;
         br_cond_q  <= br_cond_d;
         mem_rd_q   <= mem_rd_d;
         load_ir_q  <= load_ir_d;
         incp_q     <= incp_d;
         tsel_q     <= tsel_d;
         execb_q    <= execb_d;
         cond_q     <= cond_d;
         dp_start_q <= dp_start_d;
         halted_q   <= halted_d;
         err_q      <= err_d;
      end
   end

   assign bus.mem_rd   = mem_rd_q;
   assign bus.load_ir  = load_ir_q;
   assign bus.incp     = incp_q;
   assign bus.tsel     = tsel_q;
   assign bus.execb    = execb_q;
   assign bus.cond     = cond_q;
   assign bus.dp_start = dp_start_q;
   assign bus.halted   = halted_q;
   assign bus.err      = err_q;

`ifdef PC_SEQ_RETIRE_CNT_EN
   logic [15:0] retired_q;

   // Counts instructions that complete back into FETCH; wraps naturally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         retired_q <= 16'h0000;
      end else if (((state_q == S_BRANCH) || (state_q == S_EXEC)) && (state_d == S_FETCH)) begin
         retired_q <= retired_q + 16'd1;
      end
   end

   assign bus.retired = retired_q;
`else
   assign bus.retired = 16'h0000;
`endif

endmodule
